truth_table_capture: RTL and testbench
======================================

TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 SHALL have parameter N_IN, default 2, the number of gate inputs driven; legal range 1..4.
REQ-002 SHALL have parameter SETTLE, default 2, the number of wait cycles per row before sampling; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to capture one full truth table.
REQ-006 SHALL have port expected, input, 2**N_IN bits: reference table; bit r is the required output for row r.
REQ-007 SHALL have port dut_out, input, 1 bit: output of the gate under test.
REQ-008 SHALL have port stim, output, N_IN bits: gate input vector, bit 0 = in1 and bit N_IN-1 = inN, so that stim equals the row index.
REQ-009 SHALL have port busy, output, 1 bit: high while a capture is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse on capture completion.
REQ-011 SHALL have port table_out, output, 2**N_IN bits: captured table; bit r = dut_out sampled for row r.
REQ-012 SHALL have port table_valid, output, 1 bit: table_out holds a complete capture.
REQ-013 SHALL have port match, output, 1 bit: table_out == expected, registered on completion; meaningful only while table_valid is high.

Function
REQ-014 SHALL implement the states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE, start=1 SHALL move the block to SETTLE with row=0, stim=0, busy=1, table_valid=0 and table_out=0.
REQ-016 SETTLE SHALL hold stim=row for exactly SETTLE cycles, then move to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle and write dut_out into table_out[row] at the end of that cycle.
REQ-018 From SAMPLE, if row < 2**N_IN-1, the block SHALL increment row, update stim and return to SETTLE; otherwise it SHALL go to DONE.
REQ-019 DONE SHALL last one cycle with done=1, table_valid=1, match valid and busy=0, then go to IDLE.
REQ-020 Each row SHALL take SETTLE+1 cycles.
REQ-021 done SHALL be high in cycle 2**N_IN*(SETTLE+1)+1, counting the first cycle after the start-accepting edge as cycle 1.
REQ-022 start while busy SHALL be ignored; it is neither queued nor a restart.
REQ-023 start asserted in the DONE cycle SHALL be ignored; start is accepted only in IDLE.
REQ-024 table_out, table_valid and match SHALL hold their values in IDLE until the next accepted start.
REQ-025 expected SHALL be sampled only in the DONE-entry comparison and may change during a capture without effect.
REQ-026 The row counter SHALL be N_IN+1 bits wide and never wrap past 2**N_IN-1.
REQ-027 stim SHALL be 0 in IDLE and DONE.

Reset
REQ-028 rst=1 at a clock edge SHALL force the state to IDLE, row=0, stim=0, busy=0, done=0, table_out=0, table_valid=0 and match=0.
REQ-029 rst SHALL take priority over start and over every state transition.
REQ-030 Reset mid-capture SHALL abandon the capture with no done pulse.

Structure
REQ-031 The state enum, the MAX_N_IN=4 constant and the row-count width function SHALL live in shared package truth_table_pkg.
REQ-032 The per-row wait counter SHALL be sub-module settle_timer (load, count down, expire pulse), instantiated once.

Verification
REQ-033 N_IN=2, SETTLE=2, dut = XNOR of stim, expected=4'b1001, start pulse -> stim steps 0,1,2,3, each for 3 cycles; done in cycle 13; table_out=4'b1001; match=1.
REQ-034 Same setup with dut = AND and expected=4'b1001 -> table_out=4'b1000; match=0; table_valid=1.
REQ-035 start held high for the whole run -> exactly one capture and one done pulse; restart only after returning to IDLE.
REQ-036 rst asserted during row 2 -> next cycle state IDLE, stim=0, table_out=0, busy=0; no done pulse; a following start gives a correct full capture.
REQ-037 N_IN=3, SETTLE=1, dut = majority of stim -> done in cycle 17; table_out=8'b11101000.
REQ-038 expected toggled mid-capture, final expected=4'b1001 with XNOR dut -> match=1.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table capture block.
package truth_table_pkg;

    localparam int MAX_N_IN   = 4;
    localparam int MAX_SETTLE = 15;
    localparam int SETTLE_W   = $clog2(MAX_SETTLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    // One spare bit above the row index so the last-row compare never aliases row 0.
    function automatic int row_cnt_w(input int n_in);
        int n_eff;
        n_eff = (n_in > MAX_N_IN) ? MAX_N_IN : n_in;
        return n_eff + 1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Per-row wait counter: load a cycle count, count down, flag the last wait cycle.
module settle_timer
    import truth_table_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expire
);

    logic [SETTLE_W-1:0] count_q;
    logic [SETTLE_W-1:0] count_d;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - SETTLE_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count 1 marks the final wait cycle; the FSM leaves SETTLE on the following edge.
    assign expire = (count_q == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_capture.sv
// Drives every input combination onto a gate, samples its output per row and compares the table.
module truth_table_capture
    import truth_table_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        stim,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic                   table_valid,
    output logic                   match
);

    localparam int N_ROWS = 1 << N_IN;
    localparam int ROW_W  = row_cnt_w(N_IN);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [N_ROWS-1:0]   table_q, table_d;
    logic                valid_q, valid_d;
    logic                match_q, match_d;
    logic                timer_load;
    logic                timer_expire;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_W'(SETTLE)),
        .expire   (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        table_d    = table_q;
        valid_d    = valid_q;
        match_d    = match_q;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    row_d      = '0;
                    table_d    = '0;
                    valid_d    = 1'b0;
                    match_d    = 1'b0;
                    timer_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (timer_expire) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                table_d[row_q[N_IN-1:0]] = dut_out;
                if (row_q == LAST_ROW) begin
                    // expected is looked at only here, with the final row already merged in.
                    state_d = ST_DONE;
                    row_d   = '0;
                    valid_d = 1'b1;
                    match_d = (table_d == expected);
                end else begin
                    state_d    = ST_SETTLE;
                    row_d      = row_q + ROW_W'(1);
                    timer_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            table_q <= '0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            table_q <= table_d;
            valid_q <= valid_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
        done = (state_q == ST_DONE);
        stim = busy ? row_q[N_IN-1:0] : '0;
    end

    assign table_out   = table_q;
    assign table_valid = valid_q;
    assign match       = match_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Self-checking bench: two capture instances (2 inputs/settle 2, 3 inputs/settle 1) against a row/cycle model.
module tb_truth_table_capture;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic [7:0] expected;
    logic [7:0] gate;

    logic [1:0] stim_a;
    logic       busy_a, done_a, valid_a, match_a, dut_out_a;
    logic [3:0] table_a;

    logic [2:0] stim_b;
    logic       busy_b, done_b, valid_b, match_b, dut_out_b;
    logic [7:0] table_b;

    bit         sel;
    logic [2:0] o_stim;
    logic       o_busy, o_done, o_valid, o_match;
    logic [7:0] o_tbl;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    // Gate under test is an arbitrary truth table looked up by the stimulus.
    assign dut_out_a = gate[stim_a];
    assign dut_out_b = gate[stim_b];

    truth_table_capture #(.N_IN(2), .SETTLE(2)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (start_a),
        .expected    (expected[3:0]),
        .dut_out     (dut_out_a),
        .stim        (stim_a),
        .busy        (busy_a),
        .done        (done_a),
        .table_out   (table_a),
        .table_valid (valid_a),
        .match       (match_a)
    );

    truth_table_capture #(.N_IN(3), .SETTLE(1)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start_b),
        .expected    (expected),
        .dut_out     (dut_out_b),
        .stim        (stim_b),
        .busy        (busy_b),
        .done        (done_b),
        .table_out   (table_b),
        .table_valid (valid_b),
        .match       (match_b)
    );

    always_comb begin
        if (sel) begin
            o_stim  = stim_b;
            o_busy  = busy_b;
            o_done  = done_b;
            o_valid = valid_b;
            o_match = match_b;
            o_tbl   = table_b;
        end else begin
            o_stim  = {1'b0, stim_a};
            o_busy  = busy_a;
            o_done  = done_a;
            o_valid = valid_a;
            o_match = match_a;
            o_tbl   = {4'b0000, table_a};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // kind 0 = XNOR (even parity), 1 = AND, otherwise majority.
    function automatic logic [7:0] make_table(input int kind, input int n);
        logic [7:0] t;
        t = '0;
        for (int r = 0; r < (1 << n); r++) begin
            int ones;
            ones = $countones(3'(r));
            case (kind)
                0:       t[r] = (ones % 2 == 0);
                1:       t[r] = (r == (1 << n) - 1);
                default: t[r] = (2 * ones > n);
            endcase
        end
        return t;
    endfunction

    // One full capture checked every cycle from acceptance to the idle cycle after done.
    task automatic run_capture(input bit s, input logic [7:0] g, input logic [7:0] exp_final,
                               input bit toggle, input bit hold, input int mid);
        int n, st, rows, last, row;
        logic [7:0] mask, gm;
        logic exp_match;
        sel  = s;
        n    = s ? 3 : 2;
        st   = s ? 1 : 2;
        rows = 1 << n;
        last = rows * (st + 1);
        mask = 8'((1 << rows) - 1);
        gm   = g & mask;
        exp_match = (gm == (exp_final & mask));
        gate     = g;
        expected = toggle ? 8'($urandom) : exp_final;
        set_start(1'b1);
        for (int c = 1; c <= last + 2; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 && !hold) set_start(1'b0);
            if (!hold && mid != 0 && c == mid) set_start(1'b1);
            if (!hold && mid != 0 && c == mid + 1) set_start(1'b0);
            if (c <= last) begin
                row = (c - 1) / (st + 1);
                chk($sformatf("stim c%0d", c), o_stim, row);
                chk($sformatf("busy c%0d", c), o_busy, 1);
                chk($sformatf("done c%0d", c), o_done, 0);
                chk($sformatf("valid c%0d", c), o_valid, 0);
                chk($sformatf("partial table c%0d", c), o_tbl, gm & 8'((1 << row) - 1));
                if (toggle) expected = (c < last) ? 8'($urandom) : exp_final;
            end else if (c == last + 1) begin
                chk("done pulse", o_done, 1);
                chk("busy at done", o_busy, 0);
                chk("stim at done", o_stim, 0);
                chk("valid at done", o_valid, 1);
                chk("table at done", o_tbl, gm);
                chk("match at done", o_match, exp_match);
                expected = ~exp_final;
            end else begin
                chk("done after pulse", o_done, 0);
                chk("busy idle", o_busy, 0);
                chk("stim idle", o_stim, 0);
                chk("valid held", o_valid, 1);
                chk("table held", o_tbl, gm);
                chk("match held", o_match, exp_match);
            end
        end
    endtask

    initial begin
        int ndone;
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        gate     = '0;
        expected = '0;
        sel      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            chk("reset busy", o_busy, 0);
            chk("reset done", o_done, 0);
            chk("reset stim", o_stim, 0);
            chk("reset table", o_tbl, 0);
            chk("reset valid", o_valid, 0);
            chk("reset match", o_match, 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // XNOR gate against its own table, then AND against the XNOR table.
        run_capture(1'b0, make_table(0, 2), 8'h09, 1'b0, 1'b0, 0);
        chk("xnor table literal", o_tbl, 8'h09);
        run_capture(1'b0, make_table(1, 2), 8'h09, 1'b0, 1'b0, 0);
        chk("and table literal", o_tbl, 8'h08);
        chk("and match literal", o_match, 0);

        // start held through a whole run: one capture, restart only from IDLE.
        run_capture(1'b0, make_table(0, 2), 8'h09, 1'b0, 1'b1, 0);
        run_capture(1'b0, make_table(1, 2), 8'h08, 1'b0, 1'b0, 0);

        // Reset during row 2 abandons the capture silently.
        sel      = 1'b0;
        gate     = make_table(0, 2);
        expected = 8'h09;
        start_a  = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("row2 stim before reset", o_stim, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post-reset busy", o_busy, 0);
        chk("post-reset stim", o_stim, 0);
        chk("post-reset table", o_tbl, 0);
        chk("post-reset valid", o_valid, 0);
        chk("post-reset done", o_done, 0);
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            ndone += int'(o_done);
        end
        chk("no done after reset", ndone, 0);
        run_capture(1'b0, make_table(0, 2), 8'h09, 1'b0, 1'b0, 0);

        // Three-input majority, done in cycle 17.
        run_capture(1'b1, make_table(2, 3), 8'hE8, 1'b0, 1'b0, 0);
        chk("majority literal", o_tbl, 8'hE8);

        // expected wanders mid-capture; only its final value counts.
        run_capture(1'b0, make_table(0, 2), 8'h09, 1'b1, 1'b0, 0);

        // Random gates, random references, stray start pulses while busy.
        for (int k = 0; k < 10; k++) begin
            bit rs;
            logic [7:0] g, e;
            int mid;
            rs  = bit'($urandom_range(0, 1));
            g   = 8'($urandom);
            e   = ($urandom_range(0, 1) == 1) ? g : 8'($urandom);
            mid = rs ? int'($urandom_range(2, 15)) : int'($urandom_range(2, 11));
            run_capture(rs, g, e, bit'($urandom_range(0, 1)), 1'b0, mid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
